ps2_keyboard_rx: RTL

Receives the PS/2 keyboard stream that the HPS bridge emits (ps2 clock/data pair) and decodes it into complete make/break key events for the UK101 keyboard matrix logic.
- Runs in the core system clock domain (50 MHz); ps2 inputs are asynchronous to it.
- Handles deglitching, frame validation, watchdog recovery and the E0/F0 prefix sequences.
- Downstream matrix logic sees one clean event per key action.

---
 rtl/ps2_keyboard_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
//  Module   : ps2_keyboard_rx
//  Brief    : PS/2 keyboard receiver; deglitches the ps2 clock, validates
//             frames and folds E0/F0 prefixes into make/break key events.
//             Optional event FIFO enabled by defining PS2_RX_FIFO_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int          WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  FLT_LAST = 8'(FILTER_LEN - 1);

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic [1:0]      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bits_q, bits_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            ext_q, ext_d, rel_q, rel_d;
  logic            perr_d, ferr_d, drop;
  logic            byte_ok, push, fall;
  logic            perr_q, ferr_q;
  logic [9:0]      ev;

  // The level only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = ~filt_q;
      else                    fcnt_d = fcnt_q + 8'd1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    par_d   = par_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    byte_ok = 1'b0;
    push    = 1'b0;
    wd_d    = (fall || state_q == S_IDLE) ? '0 : wd_q + 1'b1;
    if (state_q != S_IDLE && !fall && wd_q == WD_LAST) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state_q)
        S_IDLE: if (!dat_s2_q) begin
          state_d = S_DATA;
          bits_d  = 3'd0;
        end
        S_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (!dat_s2_q)              ferr_d  = 1'b1;
          else if (~^{shift_q, par_q}) perr_d  = 1'b1;
          else                        byte_ok = 1'b1;
        end
      endcase
    end
    if (byte_ok) begin
      if (shift_q == 8'hE0)      ext_d = 1'b1;
      else if (shift_q == 8'hF0) rel_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  assign ev = {ext_q, rel_q, shift_q};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bits_q   <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d | drop;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

`ifdef PS2_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          pop, full, do_push;

  assign pop     = (cnt_q != '0) && code_ready;
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= ev;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
    end
  end

  assign code_valid                      = (cnt_q != '0);
  assign {extended, released, scan_code} = mem_q[rd_q];
`else
  logic [9:0] out_q;
  logic       valid_q;
  logic       unused_cfg;

  assign drop       = 1'b0;
  assign unused_cfg = code_ready ^ (FIFO_DEPTH == 0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= push;
      if (push) out_q <= ev;
    end
  end

  assign code_valid                      = valid_q;
  assign {extended, released, scan_code} = out_q;
`endif

endmodule

`default_nettype wire
